muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle HI/LO multiply/divide sequencer for the pipelined MIPS core, beside the ALU in EX.
//  - Runs MULT/MULTU/DIV/DIVU as one shift-add/sub step per cycle, WIDTH steps per op.
//  - Owns the architectural HI/LO registers.
//  - Raises busy so the hazard logic stalls MFHI/MFLO and any new muldiv op until done.
// PARAMETERS
//  WIDTH   32              operand/HI/LO width; iteration count = WIDTH
//  CNT_W   $clog2(WIDTH)+1 iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active-low
//  start      in   1      op request, sampled each cycle
//  op         in   3      MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO (3'b000 = none)
//  src_a      in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//  src_b      in   WIDTH  rt: multiplier / divisor
//  cancel     in   1      pipeline flush of the in-flight op
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
//  busy       out  1      op in flight (decoded from the state register)
//  done       out  1      one-cycle pulse: HI/LO just updated by a mul/div
// BEHAVIOUR
//  Reset (rst_n=0 at an edge, also mid-op): state=IDLE, hi=lo=0, busy=0, done=0, counter=0.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//   - IDLE: start with a mul/div op latches the operands and goes to CALC.
//   - Signed ops latch magnitudes plus the result signs: quotient/product sign = a^b, remainder sign = a.
//   - CALC: exactly WIDTH cycles, one step per cycle, counter WIDTH-1 down to 0, then FIX.
//   - FIX: one cycle; applies the sign negation, writes hi/lo, then IDLE.
//  Timing: start accepted in cycle T -> busy=1 in T+1..T+WIDTH+1; hi/lo and done=1 visible in T+WIDTH+2.
//  MTHI/MTLO in IDLE: hi/lo written at that edge, visible T+1; no busy, no done.
//  Mul: 2*WIDTH-bit product; hi = upper half, lo = lower half.
//  Div: restoring divide; lo = quotient, hi = remainder.
//  Div by zero (signed or unsigned): lo = all ones, hi = src_a unmodified; still full latency.
//  DIV of most-negative by -1: lo = 0x80000000, hi = 0 (wraps, no trap).
//  start while busy: ignored; the hazard unit guarantees it does not happen (bench assertion).
//  start with op=none: ignored.
//  cancel:
//   - While busy: state=IDLE at next edge, hi/lo keep pre-op values, no done.
//   - In the FIX cycle: cancel wins, no write.
//   - Simultaneous with start in IDLE: cancel wins; the op, including MTHI/MTLO, is dropped.
//  done never asserts in the same cycle as busy.
// STRUCTURE
//  Shared package mips_pkg:
//   - MD_* op encodings.
//   - md_state_t enum {MD_IDLE, MD_CALC, MD_FIX}.
//  Sub-module muldiv_step: combinational single iteration.
//   - Mul: conditional add + shift.
//   - Div: trial subtract + shift.
//   - The FSM registers the accumulator/quotient around it.
// TESTING
//  1 MULT a=-3 b=7 at T -> busy T+1..T+33, done@T+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3 DIVU 100/7 -> lo=14, hi=2.
//    DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5 at T+34.
//    MTHI 0x1234 in IDLE -> hi=0x1234 at T+1, busy stays 0.
//  5 hi=lo=0xA5A5A5A5, DIV started, cancel at T+10 -> busy=0 at T+11, hi/lo unchanged, no done.
//    start+cancel same cycle -> nothing happens.
//  6 rst_n=0 at T+20 of a MULT -> next cycle hi=lo=0, busy=0.
//    New MULT 6*7 after reset -> lo=42.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: HI/LO sequencer op encodings and FSM states.
package mips_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  function automatic logic md_is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the HI/LO sequencer: shift-add for multiply,
// restoring trial-subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Single multiply or divide step on the {acc, mq} pair
  always_comb begin
    sum_s   = {1'b0, acc} + {1'b0, m};
    shl_s   = {acc, mq[WIDTH-1]};
    // When the trial subtract succeeds the true difference is below m, so
    // the low WIDTH bits of the modular difference are exact.
    diff_s  = shl_s[WIDTH-1:0] - m;
    ge_s    = (shl_s >= {1'b0, m});
    acc_nxt = acc;
    mq_nxt  = mq;
    if (is_div) begin
      if (ge_s) begin
        acc_nxt = diff_s;
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shl_s[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (mq[0]) begin
        acc_nxt = sum_s[WIDTH:1];
        mq_nxt  = {sum_s[0], mq[WIDTH-1:1]};
      end else begin
        acc_nxt = {1'b0, acc[WIDTH-1:1]};
        mq_nxt  = {acc[0], mq[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO
// registers; busy stalls dependent instructions until the op completes.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_t          state_r;
  md_state_t          state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   mq_r;
  logic [WIDTH-1:0]   m_r;
  logic [WIDTH-1:0]   a_raw_r;
  logic               is_div_r;
  logic               res_neg_r;
  logic               rem_neg_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;

  logic               load_s;
  logic               step_s;
  logic               write_s;
  logic               mthi_s;
  logic               mtlo_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   mq_nxt_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   hi_res_s;
  logic [WIDTH-1:0]   lo_res_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_r),
    .acc     (acc_r),
    .mq      (mq_r),
    .m       (m_r),
    .acc_nxt (acc_nxt_s),
    .mq_nxt  (mq_nxt_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath control; cancel always beats start and the FIX write
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    write_s     = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (start && !cancel) begin
          if (md_is_muldiv(op)) begin
            load_s      = 1'b1;
            state_nxt_s = MD_CALC;
          end else if (op == MD_MTHI) begin
            mthi_s = 1'b1;
          end else if (op == MD_MTLO) begin
            mtlo_s = 1'b1;
          end else begin
            state_nxt_s = MD_IDLE;
          end
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (cancel) begin
          state_nxt_s = MD_IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt_s = MD_FIX;
          end else begin
            state_nxt_s = MD_CALC;
          end
        end
      end
      MD_FIX: begin
        if (cancel) begin
          state_nxt_s = MD_IDLE;
        end else begin
          write_s     = 1'b1;
          state_nxt_s = MD_IDLE;
        end
      end
      default: begin
        state_nxt_s = MD_IDLE;
      end
    endcase
  end

  // Operand magnitudes for the signed ops, and the final sign fix-up
  always_comb begin
    a_neg_s  = md_is_signed(op) & src_a[WIDTH-1];
    b_neg_s  = md_is_signed(op) & src_b[WIDTH-1];
    a_mag_s  = a_neg_s ? (~src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : src_a;
    b_mag_s  = b_neg_s ? (~src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : src_b;
    prod_s   = res_neg_r ? (~{acc_r, mq_r} + {{(2*WIDTH-1){1'b0}}, 1'b1}) : {acc_r, mq_r};
    hi_res_s = prod_s[2*WIDTH-1:WIDTH];
    lo_res_s = prod_s[WIDTH-1:0];
    if (is_div_r) begin
      if (dbz_r) begin
        hi_res_s = a_raw_r;
        lo_res_s = {WIDTH{1'b1}};
      end else begin
        hi_res_s = rem_neg_r ? (~acc_r + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_r;
        lo_res_s = res_neg_r ? (~mq_r + {{(WIDTH-1){1'b0}}, 1'b1}) : mq_r;
      end
    end else begin
      hi_res_s = prod_s[2*WIDTH-1:WIDTH];
      lo_res_s = prod_s[WIDTH-1:0];
    end
  end

  // Iteration datapath: operand latch, per-step update and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      mq_r      <= {WIDTH{1'b0}};
      m_r       <= {WIDTH{1'b0}};
      a_raw_r   <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      dbz_r     <= 1'b0;
    end else if (load_s) begin
      cnt_r     <= CNT_W'(WIDTH - 1);
      acc_r     <= {WIDTH{1'b0}};
      // Multiply: mq holds the multiplier, m the multiplicand.
      // Divide: mq holds the dividend, m the divisor.
      mq_r      <= md_is_div(op) ? a_mag_s : b_mag_s;
      m_r       <= md_is_div(op) ? b_mag_s : a_mag_s;
      a_raw_r   <= src_a;
      is_div_r  <= md_is_div(op);
      res_neg_r <= a_neg_s ^ b_neg_s;
      rem_neg_r <= a_neg_s;
      dbz_r     <= (src_b == {WIDTH{1'b0}});
    end else if (step_s) begin
      acc_r <= acc_nxt_s;
      mq_r  <= mq_nxt_s;
      if (cnt_r != {CNT_W{1'b0}}) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Architectural HI/LO and the completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      done_r <= 1'b0;
    end else begin
      done_r <= write_s;
      if (write_s) begin
        hi_r <= hi_res_s;
        lo_r <= lo_res_s;
      end else if (mthi_s) begin
        hi_r <= src_a;
      end else if (mtlo_s) begin
        lo_r <= src_a;
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign done = done_r;
  assign busy = (state_r != MD_IDLE);

endmodule
